vita49_stream_processor: RTL and testbench
==========================================

VITA49_STREAM_PROCESSOR -- requirements
Module: vita49_stream_processor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of sample channels (power of two, 2..16).
REQ-002 SHALL have parameter DISP_W, default 18, meaning width of display_lines (1..32).
REQ-003 SHALL have derived parameter CH_W = clog2(NUM_CH), meaning channel index width.
REQ-004 SHALL have port sys_clk  in  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port data  in  32  meaning VITA-49 word from the processor PIO.
REQ-007 SHALL have port data_ready  in  1  meaning level strobe; a rising edge presents one word.
REQ-008 SHALL have port disp_ch_sel  in  CH_W  meaning channel shown on display_lines.
REQ-009 SHALL have port display_lines  out  DISP_W  meaning latest sample[31:32-DISP_W] of the selected channel.
REQ-010 SHALL have port sample_out  out  32  meaning payload word.
REQ-011 SHALL have port sample_ch  out  CH_W  meaning channel of sample_out.
REQ-012 SHALL have port sample_valid  out  1  meaning one-cycle pulse qualifying sample_out and sample_ch.
REQ-013 SHALL have ports pkt_done, size_err, seq_err  out  1 each  meaning one-cycle status pulses.
REQ-014 SHALL have port busy  out  1  meaning FSM is not in HDR.

Function
REQ-015 SHALL accept a word in the cycle where data_ready=1 and the registered data_ready was 0; a held level SHALL NOT accept again.
REQ-016 SHALL decode the header as type[31:28], cid[27], trl[26], tsi[23:22], tsf[21:20], cnt[19:16], size[15:0] (32-bit words, header included).
REQ-017 SHALL compute overhead = 1 + sid + 2*cid + (tsi!=0) + 2*(tsf!=0) + trl, where sid=1 for types 1 and 3, else 0; width 17 bits, no truncation.
REQ-018 SHALL, when size < overhead, including size=0, pulse size_err, discard the header and remain in HDR.
REQ-019 SHALL step the FSM through HDR -> SID -> CID -> TSI -> TSF -> PAY -> TRL -> HDR, skipping absent fields, with a down-counter per multi-word field.
REQ-020 SHALL route payload of types 0/2 to channel 0 and of types 1/3 to channel stream_id[CH_W-1:0].
REQ-021 SHALL treat types 4..15 as SKIP: consume size-1 words, emit no samples, and then pulse pkt_done.
REQ-022 SHALL register each payload word so that sample_valid pulses exactly one cycle after the accepting edge, and SHALL update that channel's latest-sample register in the same cycle.
REQ-023 SHALL allow zero payload, going directly to TRL or HDR.
REQ-024 SHALL pulse pkt_done one cycle after the last word of a packet is accepted; a single-word packet SHALL pulse it one cycle after the header.
REQ-025 SHALL make display_lines combinational from disp_ch_sel and the registered per-channel samples.
REQ-026 SHALL ignore a data_ready edge coinciding with reset deassertion; the edge register SHALL reset to 1 so a held-high strobe is not accepted.

Reset
REQ-027 SHALL, on reset (including mid-packet), force the FSM to HDR, clear all counters, per-channel samples, display_lines, sample_out, sample_ch and seq state to 0, and drive all pulses and busy to 0.

Configuration
REQ-028 SHALL, with VITA49_SEQ_CHECK_EN defined, keep a per-channel 4-bit expected count and valid bit, check cnt when the channel is known (header for types 0/2, SID word for types 1/3), pulse seq_err on mismatch, and set expected=cnt+1 mod 16; the first packet per channel after reset SHALL only initialise.
REQ-029 SHALL, without VITA49_SEQ_CHECK_EN, tie seq_err to 0 and instantiate no seq state.

Structure
REQ-030 SHALL place the FSM state enum, header bit positions and packet-type constants in package vita49_pkg.
REQ-031 SHALL implement sequence tracking as sub-module vita49_seq_tracker, instantiated only under VITA49_SEQ_CHECK_EN.

Verification
REQ-032 SHALL cover: type 1 header size=5, SID=0x2, payload 0xA5A50001/0xA5A50002/0xA5A50003 -> three sample_valid with sample_ch=2, pkt_done after third, display_lines (sel=2, DISP_W=18) = 0x29694.
REQ-033 SHALL cover: header size=0 -> size_err pulse, busy stays 0, next valid packet processed normally.
REQ-034 SHALL cover: type 0 header with tsi=1, tsf=1, trl=1, size=7 -> words 2-4 and 7 produce no sample; words 5-6 produce sample_ch=0.
REQ-035 SHALL cover: type 4, size=4 -> no sample_valid, pkt_done after fourth word.
REQ-036 SHALL cover: reset asserted after the second payload word of a size-6 packet -> all outputs 0, next word is decoded as a header.
REQ-037 SHALL cover, with VITA49_SEQ_CHECK_EN: channel 1 cnt 3 then cnt 5 -> seq_err on the second SID word; then cnt 6 -> no seq_err.

Source files
------------

// File: rtl/vita49_pkg.sv
// Shared VITA-49 decode definitions: FSM states, header bit positions,
// packet-type constants and the field-sequencing helper.
package vita49_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_SID,
        ST_CID,
        ST_TSI,
        ST_TSF,
        ST_PAY,
        ST_TRL,
        ST_SKIP
    } state_t;

    localparam int HDR_TYPE_MSB = 31;
    localparam int HDR_TYPE_LSB = 28;
    localparam int HDR_CID_BIT  = 27;
    localparam int HDR_TRL_BIT  = 26;
    localparam int HDR_TSI_MSB  = 23;
    localparam int HDR_TSI_LSB  = 22;
    localparam int HDR_TSF_MSB  = 21;
    localparam int HDR_TSF_LSB  = 20;
    localparam int HDR_CNT_MSB  = 19;
    localparam int HDR_CNT_LSB  = 16;
    localparam int HDR_SIZE_MSB = 15;
    localparam int HDR_SIZE_LSB = 0;

    localparam logic [3:0] TYPE_DATA_SID = 4'd1;
    localparam logic [3:0] TYPE_EXT_SID  = 4'd3;
    localparam logic [3:0] TYPE_SKIP_MIN = 4'd4;

    typedef struct packed {
        logic sid;
        logic cid;
        logic tsi;
        logic tsf;
        logic pay;
        logic trl;
    } fields_t;

    function automatic logic type_has_sid(input logic [3:0] t);
        return (t == TYPE_DATA_SID) || (t == TYPE_EXT_SID);
    endfunction

    function automatic logic type_is_skip(input logic [3:0] t);
        return t >= TYPE_SKIP_MIN;
    endfunction

    // First present field strictly after cur; ST_SKIP and ST_TRL both fall through to ST_HDR.
    function automatic state_t next_field(input state_t cur, input fields_t f);
        if (cur < ST_SID && f.sid) return ST_SID;
        if (cur < ST_CID && f.cid) return ST_CID;
        if (cur < ST_TSI && f.tsi) return ST_TSI;
        if (cur < ST_TSF && f.tsf) return ST_TSF;
        if (cur < ST_PAY && f.pay) return ST_PAY;
        if (cur < ST_TRL && f.trl) return ST_TRL;
        return ST_HDR;
    endfunction

endpackage

// File: rtl/vita49_seq_tracker.sv
// Per-channel packet-count continuity checker; only built when
// VITA49_SEQ_CHECK_EN is defined.
module vita49_seq_tracker
    import vita49_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            hdr_acc,
    input  logic            hdr_sid,
    input  logic [3:0]      hdr_cnt,
    input  logic            sid_acc,
    input  logic [CH_W-1:0] sid_ch,
    output logic            seq_err
);

    logic [3:0]        pend_cnt;
    logic [3:0]        exp_cnt [NUM_CH];
    logic [NUM_CH-1:0] exp_vld;
    logic              chk;
    logic [CH_W-1:0]   chk_ch;
    logic [3:0]        chk_cnt;

    // Streams with a stream ID only learn their channel on the SID word.
    always_comb begin
        chk     = 1'b0;
        chk_ch  = '0;
        chk_cnt = hdr_cnt;
        if (hdr_acc && !hdr_sid) begin
            chk = 1'b1;
        end else if (sid_acc) begin
            chk     = 1'b1;
            chk_ch  = sid_ch;
            chk_cnt = pend_cnt;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            pend_cnt <= '0;
            exp_vld  <= '0;
            seq_err  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) exp_cnt[i] <= '0;
        end else begin
            seq_err <= 1'b0;
            if (hdr_acc && hdr_sid) pend_cnt <= hdr_cnt;
            if (chk) begin
                if (exp_vld[chk_ch] && exp_cnt[chk_ch] != chk_cnt) seq_err <= 1'b1;
                exp_cnt[chk_ch] <= chk_cnt + 4'd1;
                exp_vld[chk_ch] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vita49_stream_processor.sv
// VITA-49 packet parser: demultiplexes payload words per channel.
// Optional sequence checking is enabled with `define VITA49_SEQ_CHECK_EN.
module vita49_stream_processor
    import vita49_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DISP_W = 18,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [31:0]       data,
    input  logic              data_ready,
    input  logic [CH_W-1:0]   disp_ch_sel,
    output logic [DISP_W-1:0] display_lines,
    output logic [31:0]       sample_out,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    output logic              pkt_done,
    output logic              size_err,
    output logic              seq_err,
    output logic              busy
);

    state_t          state;
    fields_t         fields_q;
    logic [15:0]     pay_len;
    logic [15:0]     word_cnt;
    logic [CH_W-1:0] cur_ch;
    logic            dr_q;
    logic [31:0]     samples [NUM_CH];

    logic            accept;
    logic [3:0]      h_type;
    logic [15:0]     h_size;
    logic [16:0]     overhead;
    logic            size_ok;
    logic [15:0]     h_pay;
    fields_t         h_fields;
    state_t          h_next;
    state_t          f_next;

    function automatic logic [15:0] field_len(input state_t st, input logic [15:0] pay);
        case (st)
            ST_CID, ST_TSF: return 16'd1;
            ST_PAY:         return pay - 16'd1;
            default:        return 16'd0;
        endcase
    endfunction

    assign accept        = data_ready && !dr_q;
    assign busy          = (state != ST_HDR);
    assign display_lines = samples[disp_ch_sel][31 -: DISP_W];

    always_comb begin
        h_type   = data[HDR_TYPE_MSB:HDR_TYPE_LSB];
        h_size   = data[HDR_SIZE_MSB:HDR_SIZE_LSB];
        overhead = 17'd1 + 17'(type_has_sid(h_type))
                 + (data[HDR_CID_BIT] ? 17'd2 : 17'd0)
                 + 17'(data[HDR_TSI_MSB:HDR_TSI_LSB] != 2'd0)
                 + ((data[HDR_TSF_MSB:HDR_TSF_LSB] != 2'd0) ? 17'd2 : 17'd0)
                 + 17'(data[HDR_TRL_BIT]);
        size_ok  = {1'b0, h_size} >= overhead;
        h_pay    = h_size - overhead[15:0];
        h_fields.sid = type_has_sid(h_type);
        h_fields.cid = data[HDR_CID_BIT];
        h_fields.tsi = data[HDR_TSI_MSB:HDR_TSI_LSB] != 2'd0;
        h_fields.tsf = data[HDR_TSF_MSB:HDR_TSF_LSB] != 2'd0;
        h_fields.pay = h_pay != 16'd0;
        h_fields.trl = data[HDR_TRL_BIT];
        h_next   = next_field(ST_HDR, h_fields);
        f_next   = next_field(state, fields_q);
    end

    // word_cnt holds the words still to come in the current field after this one.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state        <= ST_HDR;
            fields_q     <= '0;
            pay_len      <= '0;
            word_cnt     <= '0;
            cur_ch       <= '0;
            dr_q         <= 1'b1;
            sample_out   <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            pkt_done     <= 1'b0;
            size_err     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) samples[i] <= '0;
        end else begin
            dr_q         <= data_ready;
            sample_valid <= 1'b0;
            pkt_done     <= 1'b0;
            size_err     <= 1'b0;
            if (accept) begin
                if (state == ST_HDR) begin
                    if (!size_ok) begin
                        size_err <= 1'b1;
                    end else if (type_is_skip(h_type)) begin
                        if (h_size == 16'd1) begin
                            pkt_done <= 1'b1;
                        end else begin
                            state    <= ST_SKIP;
                            word_cnt <= h_size - 16'd2;
                        end
                    end else begin
                        fields_q <= h_fields;
                        pay_len  <= h_pay;
                        cur_ch   <= '0;
                        state    <= h_next;
                        word_cnt <= field_len(h_next, h_pay);
                        if (h_next == ST_HDR) pkt_done <= 1'b1;
                    end
                end else begin
                    if (state == ST_SID) cur_ch <= data[CH_W-1:0];
                    if (state == ST_PAY) begin
                        sample_out      <= data;
                        sample_ch       <= cur_ch;
                        sample_valid    <= 1'b1;
                        samples[cur_ch] <= data;
                    end
                    if (word_cnt != 16'd0) begin
                        word_cnt <= word_cnt - 16'd1;
                    end else begin
                        state    <= f_next;
                        word_cnt <= field_len(f_next, pay_len);
                        if (f_next == ST_HDR) pkt_done <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef VITA49_SEQ_CHECK_EN
    vita49_seq_tracker #(.NUM_CH(NUM_CH)) u_seq (
        .sys_clk (sys_clk),
        .reset   (reset),
        .hdr_acc (accept && state == ST_HDR && size_ok && !type_is_skip(h_type)),
        .hdr_sid (type_has_sid(h_type)),
        .hdr_cnt (data[HDR_CNT_MSB:HDR_CNT_LSB]),
        .sid_acc (accept && state == ST_SID),
        .sid_ch  (data[CH_W-1:0]),
        .seq_err (seq_err)
    );
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_vita49_stream_processor.sv
// Directed self-checking bench for vita49_stream_processor (default parameters);
// the sequence-error expectations follow VITA49_SEQ_CHECK_EN.
module tb_vita49_stream_processor;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic        data_ready;
    logic [1:0]  disp_ch_sel;
    logic [17:0] display_lines;
    logic [31:0] sample_out;
    logic [1:0]  sample_ch;
    logic        sample_valid;
    logic        pkt_done;
    logic        size_err;
    logic        seq_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic        obs_sv, obs_pd, obs_se, obs_qe, obs_busy;
    logic [1:0]  obs_ch;
    logic [31:0] obs_out;

`ifdef VITA49_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    vita49_stream_processor dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .data          (data),
        .data_ready    (data_ready),
        .disp_ch_sel   (disp_ch_sel),
        .display_lines (display_lines),
        .sample_out    (sample_out),
        .sample_ch     (sample_ch),
        .sample_valid  (sample_valid),
        .pkt_done      (pkt_done),
        .size_err      (size_err),
        .seq_err       (seq_err),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mk_hdr(input logic [3:0] t, input logic cid, input logic trl,
                                           input logic [1:0] tsi, input logic [1:0] tsf,
                                           input logic [3:0] cnt, input logic [15:0] size);
        return {t, cid, trl, 2'b00, tsi, tsf, cnt, size};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One strobe per word: accepting edge, capture pulses, then an idle cycle.
    task automatic applyStimulus(input logic [31:0] word);
        data       = word;
        data_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        obs_sv   = sample_valid;
        obs_ch   = sample_ch;
        obs_out  = sample_out;
        obs_pd   = pkt_done;
        obs_se   = size_err;
        obs_qe   = seq_err;
        obs_busy = busy;
        data_ready = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        data        = mk_hdr(4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'd1);
        data_ready  = 1'b1;
        disp_ch_sel = 2'd0;
        repeat (2) @(posedge sys_clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sv", sample_valid, 0);
        checkOutput("rst_out", sample_out, 0);
        checkOutput("rst_disp", display_lines, 0);
        checkOutput("rst_pd", pkt_done, 0);

        // strobe already high when reset releases must not be taken
        reset = 1'b0;
        @(posedge sys_clk);
        #1;
        checkOutput("rst_edge_pd", pkt_done, 0);
        @(posedge sys_clk);
        #1;
        data_ready = 1'b0;
        @(posedge sys_clk);
        #1;

        // type 1, SID=2, three payload words
        applyStimulus(mk_hdr(4'd1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'd5));
        checkOutput("t1_hdr_busy", obs_busy, 1);
        checkOutput("t1_hdr_sv", obs_sv, 0);
        applyStimulus(32'h0000_0002);
        checkOutput("t1_sid_sv", obs_sv, 0);
        applyStimulus(32'hA5A5_0001);
        checkOutput("t1_p1_sv", obs_sv, 1);
        checkOutput("t1_p1_ch", obs_ch, 2);
        checkOutput("t1_p1_out", obs_out, 32'hA5A5_0001);
        checkOutput("t1_p1_pd", obs_pd, 0);
        applyStimulus(32'hA5A5_0002);
        checkOutput("t1_p2_sv", obs_sv, 1);
        checkOutput("t1_p2_pd", obs_pd, 0);
        applyStimulus(32'hA5A5_0003);
        checkOutput("t1_p3_sv", obs_sv, 1);
        checkOutput("t1_p3_ch", obs_ch, 2);
        checkOutput("t1_p3_pd", obs_pd, 1);
        checkOutput("t1_done_busy", busy, 0);
        disp_ch_sel = 2'd2;
        #1;
        checkOutput("t1_disp", display_lines, 18'h29694);
        disp_ch_sel = 2'd1;
        #1;
        checkOutput("t1_disp_other", display_lines, 0);

        // size 0 and size below overhead, then a single-word packet
        applyStimulus(mk_hdr(4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'd0));
        checkOutput("sz0_err", obs_se, 1);
        checkOutput("sz0_busy", obs_busy, 0);
        checkOutput("sz0_pd", obs_pd, 0);
        applyStimulus(mk_hdr(4'd1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 16'd3));
        checkOutput("szlow_err", obs_se, 1);
        checkOutput("szlow_busy", obs_busy, 0);
        applyStimulus(mk_hdr(4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'd1));
        checkOutput("single_err", obs_se, 0);
        checkOutput("single_pd", obs_pd, 1);
        checkOutput("single_sv", obs_sv, 0);
        checkOutput("single_busy", obs_busy, 0);

        // type 0 with TSI, TSF, trailer: words 5 and 6 are payload
        applyStimulus(mk_hdr(4'd0, 1'b0, 1'b1, 2'd1, 2'd1, 4'd1, 16'd7));
        checkOutput("ts_hdr_busy", obs_busy, 1);
        applyStimulus(32'h1111_1111);
        checkOutput("ts_w2_sv", obs_sv, 0);
        applyStimulus(32'h2222_2222);
        checkOutput("ts_w3_sv", obs_sv, 0);
        applyStimulus(32'h3333_3333);
        checkOutput("ts_w4_sv", obs_sv, 0);
        applyStimulus(32'hDEAD_BEEF);
        checkOutput("ts_w5_sv", obs_sv, 1);
        checkOutput("ts_w5_ch", obs_ch, 0);
        checkOutput("ts_w5_out", obs_out, 32'hDEAD_BEEF);
        applyStimulus(32'hC000_4000);
        checkOutput("ts_w6_sv", obs_sv, 1);
        checkOutput("ts_w6_ch", obs_ch, 0);
        checkOutput("ts_w6_pd", obs_pd, 0);
        applyStimulus(32'h7777_7777);
        checkOutput("ts_w7_sv", obs_sv, 0);
        checkOutput("ts_w7_pd", obs_pd, 1);
        disp_ch_sel = 2'd0;
        #1;
        checkOutput("ts_disp", display_lines, 18'h30001);

        // type 4 is consumed silently
        applyStimulus(mk_hdr(4'd4, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'd4));
        checkOutput("skip_hdr_busy", obs_busy, 1);
        applyStimulus(32'h0000_0001);
        checkOutput("skip_w2_sv", obs_sv, 0);
        applyStimulus(32'h0000_0002);
        checkOutput("skip_w3_pd", obs_pd, 0);
        applyStimulus(32'h0000_0003);
        checkOutput("skip_w4_sv", obs_sv, 0);
        checkOutput("skip_w4_pd", obs_pd, 1);
        checkOutput("skip_w4_busy", obs_busy, 0);

        // held strobe accepts only once
        data       = mk_hdr(4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd2, 16'd2);
        data_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("hold_sv", sample_valid, 0);
        checkOutput("hold_busy", busy, 1);
        data_ready = 1'b0;
        @(posedge sys_clk);
        #1;
        applyStimulus(32'h1234_5678);
        checkOutput("hold_p_sv", obs_sv, 1);
        checkOutput("hold_p_out", obs_out, 32'h1234_5678);
        checkOutput("hold_p_pd", obs_pd, 1);

        // reset in the middle of a size-6 packet
        applyStimulus(mk_hdr(4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd3, 16'd6));
        applyStimulus(32'hAAAA_0001);
        applyStimulus(32'hAAAA_0002);
        checkOutput("mid_p2_sv", obs_sv, 1);
        reset = 1'b1;
        #2;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_out", sample_out, 0);
        checkOutput("mid_rst_ch", sample_ch, 0);
        checkOutput("mid_rst_disp", display_lines, 0);
        checkOutput("mid_rst_sv", sample_valid, 0);
        reset = 1'b0;
        @(posedge sys_clk);
        #1;
        applyStimulus(mk_hdr(4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 16'd1));
        checkOutput("post_rst_pd", obs_pd, 1);
        checkOutput("post_rst_sv", obs_sv, 0);
        checkOutput("post_rst_busy", obs_busy, 0);

        // channel 1 count continuity: 3, 5 (gap), 6
        applyStimulus(mk_hdr(4'd1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd3, 16'd2));
        applyStimulus(32'h0000_0001);
        checkOutput("seq3_pd", obs_pd, 1);
        checkOutput("seq3_err", obs_qe, 0);
        applyStimulus(mk_hdr(4'd1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd5, 16'd2));
        checkOutput("seq5_hdr_err", obs_qe, 0);
        applyStimulus(32'h0000_0001);
        checkOutput("seq5_err", obs_qe, SEQ_ON);
        applyStimulus(mk_hdr(4'd1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd6, 16'd2));
        applyStimulus(32'h0000_0001);
        checkOutput("seq6_err", obs_qe, 0);
        checkOutput("seq6_pd", obs_pd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
